// File: rtl/dmem_port.sv
// M-stage data memory port: turns load/store requests into a single-outstanding
// bus transaction, freezing the pipeline until the bus acks or the wait times out.
module dmem_port #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluoutm,
    input  logic [31:0] writedatam,
    input  logic        memwritem,
    input  logic        memtoregm,
    output logic [31:0] readdatam,
    output logic        stallm,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       access;
    logic       aligned;
    logic       launch;
    logic       timed_out;

    assign access    = memwritem | memtoregm;
    assign aligned   = (aluoutm[1:0] == 2'b00);
    assign launch    = (state == IDLE) && access && aligned;
    assign timed_out = (wait_cnt == LAST_WAIT);

    // Held low during reset so the hazard unit never sees a stale freeze.
    assign stallm = reset && (launch || (state == BUSY));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            readdatam    <= '0;
            wait_cnt     <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && aligned) begin
                        state     <= BUSY;
                        bus_req   <= 1'b1;
                        bus_we    <= memwritem;
                        bus_addr  <= {aluoutm[31:2], 2'b00};
                        bus_wdata <= writedatam;
                        wait_cnt  <= '0;
                    end else if (access) begin
                        err_misalign <= 1'b1;
                        if (!memwritem) begin
                            readdatam <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            readdatam <= bus_rdata;
                        end
                    end else if (timed_out) begin
                        state       <= DONE;
                        bus_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        if (!bus_we) begin
                            readdatam <= ERRDATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboarded bench for dmem_port: stimulus pushes expected completions,
// a monitor pops them when a bus transaction finishes.
module tb_dmem_port;

    localparam int TO = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] aluoutm = '0;
    logic [31:0] writedatam = '0;
    logic        memwritem = 1'b0;
    logic        memtoregm = 1'b0;
    logic [31:0] readdatam;
    logic        stallm;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        err_misalign;
    logic        err_timeout;

    dmem_port #(.TIMEOUT(TO), .ERRDATA(ERR)) dut (
        .clk(clk),
        .reset(reset),
        .aluoutm(aluoutm),
        .writedatam(writedatam),
        .memwritem(memwritem),
        .memtoregm(memtoregm),
        .readdatam(readdatam),
        .stallm(stallm),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .err_misalign(err_misalign),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        to;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_rd = '0;
    logic m_to = 1'b0;
    logic rst_at_edge = 1'b0;
    logic prev_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: a bus transaction that ends without reset is a completion.
    always @(posedge clk) rst_at_edge <= reset;

    always @(negedge clk) begin
        if (prev_req && !bus_req && rst_at_edge) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion actual=%h required=none",
                         bus_addr);
            end else begin
                e = q.pop_front();
                chk("done_readdatam", readdatam, e.rd);
                chk("done_bus_we", 32'(bus_we), 32'(e.we));
                chk("done_bus_addr", bus_addr, e.addr);
                chk("done_bus_wdata", bus_wdata, e.wdata);
                chk("done_err_timeout", 32'(err_timeout), 32'(e.to));
            end
        end
        prev_req = bus_req;
    end

    task automatic do_access(input logic we, input logic re,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_at, input logic [31:0] rdata,
                             input int exp_busy);
        exp_t x;
        int n;
        @(posedge clk); #1;
        memwritem  = we;
        memtoregm  = re;
        aluoutm    = addr;
        writedatam = wdata;
        x.we    = we;
        x.addr  = addr;
        x.wdata = wdata;
        if (we) x.rd = m_rd;
        else if (ack_at >= 0) x.rd = rdata;
        else x.rd = ERR;
        m_rd = x.rd;
        if (ack_at < 0) m_to = 1'b1;
        x.to = m_to;
        q.push_back(x);
        @(negedge clk);
        chk("launch_stallm", 32'(stallm), 32'd1);
        chk("launch_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        n = 0;
        while (bus_req === 1'b1 && n < 300) begin
            bus_ack   = (n == ack_at);
            bus_rdata = (n == ack_at) ? rdata : 32'h0BAD0BAD;
            @(negedge clk);
            chk("busy_stallm", 32'(stallm), 32'd1);
            chk("busy_bus_we", 32'(bus_we), 32'(we));
            chk("busy_bus_addr", bus_addr, addr);
            chk("busy_bus_wdata", bus_wdata, wdata);
            @(posedge clk); #1;
            n++;
        end
        bus_ack = 1'b0;
        chk("busy_cycles", 32'(n), 32'(exp_busy));
        @(negedge clk);
        chk("done_stallm", 32'(stallm), 32'd0);
        chk("done_bus_req", 32'(bus_req), 32'd0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        memwritem = 1'b0;
        memtoregm = 1'b0;
        @(negedge clk);
        chk("idle_bus_req", 32'(bus_req), 32'd0);
        chk("idle_stallm", 32'(stallm), 32'd0);
    endtask

    task automatic do_misalign(input logic we, input logic re,
                               input logic [31:0] addr);
        @(posedge clk); #1;
        memwritem  = we;
        memtoregm  = re;
        aluoutm    = addr;
        writedatam = 32'h77777777;
        if (!we) m_rd = '0;
        @(negedge clk);
        chk("mis_stallm", 32'(stallm), 32'd0);
        chk("mis_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        memwritem = 1'b0;
        memtoregm = 1'b0;
        @(negedge clk);
        chk("mis_err_misalign", 32'(err_misalign), 32'd1);
        chk("mis_readdatam", readdatam, m_rd);
        chk("mis_bus_req_after", 32'(bus_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with an aligned load pending: no stall while in reset.
        memtoregm = 1'b1;
        aluoutm   = 32'h0000_0100;
        @(negedge clk);
        chk("rst_stallm", 32'(stallm), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_readdatam", readdatam, 32'd0);
        chk("rst_err_misalign", 32'(err_misalign), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_stallm2", 32'(stallm), 32'd0);
        memtoregm = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        do_access(1'b0, 1'b1, 32'h100, 32'h0, 0, 32'h12345678, 1);
        go_idle();
        do_access(1'b1, 1'b0, 32'h204, 32'hCAFEF00D, 5, 32'h0, 6);
        go_idle();
        do_access(1'b1, 1'b1, 32'h8, 32'h01020304, 2, 32'h0, 3);
        go_idle();

        // Back-to-back loads, inputs held high through DONE.
        do_access(1'b0, 1'b1, 32'h10, 32'h0, 1, 32'hA5A5A5A5, 2);
        do_access(1'b0, 1'b1, 32'h14, 32'h0, 0, 32'h3C3C3C3C, 1);
        go_idle();

        // Stray ack in IDLE.
        @(posedge clk); #1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h11112222;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_readdatam", readdatam, m_rd);
        chk("idle_ack_bus_req", 32'(bus_req), 32'd0);
        chk("idle_ack_err_timeout", 32'(err_timeout), 32'd0);

        do_misalign(1'b0, 1'b1, 32'h102);
        do_access(1'b0, 1'b1, 32'h40, 32'h0, 0, 32'h0F0F0F0F, 1);
        go_idle();
        do_misalign(1'b1, 1'b0, 32'h41);

        do_access(1'b0, 1'b1, 32'h500, 32'h0, -1, 32'h0, TO);
        go_idle();
        do_access(1'b0, 1'b1, 32'h600, 32'h0, 2, 32'h89ABCDEF, 3);
        go_idle();
        chk("sticky_err_timeout", 32'(err_timeout), 32'd1);
        chk("sticky_err_misalign", 32'(err_misalign), 32'd1);

        // Reset in the 3rd BUSY cycle, ack arriving one cycle later.
        @(posedge clk); #1;
        memtoregm = 1'b1;
        aluoutm   = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_before", 32'(bus_req), 32'd1);
        chk("abort_stallm_in_rst", 32'(stallm), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b1;
        memtoregm = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h55AA55AA;
        m_rd = '0;
        m_to = 1'b0;
        @(negedge clk);
        chk("abort_bus_req", 32'(bus_req), 32'd0);
        chk("abort_stallm", 32'(stallm), 32'd0);
        chk("abort_readdatam", readdatam, 32'd0);
        chk("abort_err_timeout", 32'(err_timeout), 32'd0);
        chk("abort_err_misalign", 32'(err_misalign), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("abort_late_ack_readdatam", readdatam, 32'd0);
        chk("abort_late_ack_bus_req", 32'(bus_req), 32'd0);

        // Port still works after the aborted transaction.
        do_access(1'b0, 1'b1, 32'h304, 32'h0, 0, 32'hFEEDFACE, 1);
        go_idle();

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max bus wait cycles before abort (range 1-255).
REQ-002 SHALL have parameter ERRDATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port aluoutm  in  32  M-stage byte address.
REQ-006 SHALL have port writedatam  in  32  M-stage store data.
REQ-007 SHALL have port memwritem  in  1  M-stage store request.
REQ-008 SHALL have port memtoregm  in  1  M-stage load request.
REQ-009 SHALL have port readdatam  out  32  load result to W pipeline register.
REQ-010 SHALL have port stallm  out  1  freeze request to hazard unit (stall F/D/E/M, bubble W).
REQ-011 SHALL have ports bus_req/bus_we  out  1 each  external request valid, write enable.
REQ-012 SHALL have ports bus_addr/bus_wdata  out  32 each  word address (byte address, bits [1:0] forced 0), store data.
REQ-013 SHALL have ports bus_ack  in  1 and bus_rdata  in  32  completion strobe, load data.
REQ-014 SHALL have ports err_misalign, err_timeout  out  1 each  sticky error flags.

Function
REQ-015 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-016 Access SHALL be defined as (memwritem | memtoregm) in IDLE; memwritem wins when both are high (treated as store).
REQ-017 Aligned access (aluoutm[1:0]==0) in IDLE SHALL go to BUSY and register bus_addr, bus_wdata, bus_we at that edge.
REQ-018 stallm SHALL be combinational: 1 in IDLE with aligned access, 1 in BUSY, 0 in DONE and otherwise.
REQ-019 bus_req SHALL be 1 exactly while in BUSY; bus_addr/bus_wdata/bus_we SHALL be stable throughout BUSY.
REQ-020 In BUSY, bus_ack=1 SHALL go to DONE; for loads, readdatam SHALL capture bus_rdata at that edge.
REQ-021 BUSY SHALL count wait cycles in an 8-bit counter cleared on entry; when the count reaches TIMEOUT without ack -> DONE, readdatam<=ERRDATA (loads), err_timeout<=1.
REQ-022 DONE SHALL last exactly one cycle, then IDLE; no new request SHALL launch from DONE.
REQ-023 readdatam SHALL hold its value until the next load completion, so W captures it at the DONE edge.
REQ-024 Minimum latency: access seen in cycle N, bus_req in N+1, ack in N+1 -> DONE in N+2; stallm high for cycles N and N+1 only.
REQ-025 Misaligned access in IDLE SHALL NOT request the bus, SHALL NOT stall, SHALL set err_misalign, and loads SHALL set readdatam<=0 at that edge.
REQ-026 bus_ack in IDLE or DONE SHALL be ignored (no state, data or flag change).
REQ-027 Back-to-back memory instructions SHALL each complete fully; a second access seen in IDLE after DONE launches normally.
REQ-028 Store completion SHALL NOT alter readdatam.
REQ-029 Error flags SHALL stay set until reset; no other clear mechanism.

Reset
REQ-030 When reset==0 at a rising edge: state<=IDLE, bus_req<=0, bus_we<=0, bus_addr<=0, bus_wdata<=0, readdatam<=0, wait counter<=0, err_misalign<=0, err_timeout<=0.
REQ-031 Reset asserted during BUSY SHALL abort the transaction: bus_req low the cycle after the reset edge; late bus_ack ignored.
REQ-032 stallm SHALL be 0 while reset is asserted.

Verification
REQ-033 Load addr 0x100, ack same cycle as bus_req, bus_rdata 0x12345678 -> stallm high 2 cycles, readdatam=0x12345678 in DONE, back to IDLE.
REQ-034 Store addr 0x204 data 0xCAFEF00D, ack after 5 wait cycles -> bus_we=1, bus_addr=0x204, bus_wdata stable all of BUSY, readdatam unchanged.
REQ-035 Load with no ack, TIMEOUT=16 -> 16 BUSY cycles then DONE, readdatam=0xDEADBEEF, err_timeout=1 and stays 1.
REQ-036 Load addr 0x102 -> no bus_req, stallm=0, err_misalign=1, readdatam=0.
REQ-037 Reset low in 3rd BUSY cycle, ack next cycle -> bus_req=0, state IDLE, readdatam=0, ack ignored.
REQ-038 memwritem and memtoregm both high, addr 0x8 -> single store on bus (bus_we=1), readdatam unchanged.
